// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;
   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} loader_state_t;
   localparam int WORD_BYTES = 4;
   localparam int LANE_W     = 2;
endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into a 32-bit word, lane 0 in bits [7:0].
// One byte per push; last_lane flags that the next push completes the word.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clr,
   input  logic                      push,
   input  logic [7:0]                byte_in,
   output logic [8*WORD_BYTES-1:0]   word_out,
   output logic                      last_lane
);
   logic [LANE_W-1:0]         lane_q, lane_d;
   logic [8*WORD_BYTES-1:0]   word_q, word_d;

   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      if (clr) begin
         lane_d = '0;
         word_d = '0;
      end else if (push) begin
         word_d[{lane_q, 3'b000} +: 8] = byte_in;
         lane_d = lane_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane_q <= '0;
         word_q <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

   assign word_out  = word_q;
   assign last_lane = (lane_q == LANE_W'(WORD_BYTES - 1));
endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream in, one imem word write per 4 accepted bytes, core held while busy.
// Outputs are register-decoded; byte_ready drops during WRITE and outside a session.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_words,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             we,
   output logic [31:0]      wa,
   output logic [31:0]      wd,
   output logic             busy,
   output logic             cpu_hold,
   output logic             done,
   output logic             err
);
   loader_state_t    state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] word_idx_q, word_idx_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             byte_ready_q, byte_ready_d;
   logic             we_q, we_d;
   logic             busy_q, busy_d;
   logic             pk_clr, pk_push, pk_last;
   logic [31:0]      pk_word;

   byte_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clr       (pk_clr),
      .push      (pk_push),
      .byte_in   (byte_data),
      .word_out  (pk_word),
      .last_lane (pk_last)
   );

   assign pk_push = byte_ready_q && byte_valid;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      done_d     = done_q;
      err_d      = err_q;
      pk_clr     = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               pk_clr     = 1'b1;
               word_idx_d = '0;
               done_d     = 1'b0;
               err_d      = 1'b0;
               if (num_words == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (num_words > CNT_W'(DEPTH)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  count_d = num_words;
                  state_d = RECV;
               end
            end
         end
         RECV: begin
            if (pk_push && pk_last) state_d = WRITE;
         end
         WRITE: begin
            if (word_idx_q == count_q - 1'b1) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               word_idx_d = word_idx_q + 1'b1;
               state_d    = RECV;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake/strobe outputs follow the next state so they are valid from the first cycle in it.
   always_comb begin
      byte_ready_d = (state_d == RECV);
      we_d         = (state_d == WRITE);
      busy_d       = (state_d == RECV) || (state_d == WRITE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         count_q      <= '0;
         word_idx_q   <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         byte_ready_q <= 1'b0;
         we_q         <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         word_idx_q   <= word_idx_d;
         done_q       <= done_d;
         err_q        <= err_d;
         byte_ready_q <= byte_ready_d;
         we_q         <= we_d;
         busy_q       <= busy_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign we         = we_q;
   assign wa         = {{(32-CNT_W-2){1'b0}}, word_idx_q, 2'b00};
   assign wd         = pk_word;
   assign busy       = busy_q;
   assign cpu_hold   = busy_q;
   assign done       = done_q;
   assign err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; inputs driven and outputs sampled on negedges.
module tb_imem_loader;
   localparam int DEPTH = 64;
   localparam int CNT_W = 7;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] num_words;
   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             byte_ready, we, busy, cpu_hold, done, err;
   logic [31:0]      wa, wd;

   imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .num_words(num_words),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .we(we), .wa(wa), .wd(wd), .busy(busy), .cpu_hold(cpu_hold),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int start_cyc = 0;
   logic [31:0] wa_log[$];
   logic [31:0] wd_log[$];
   bit busy_seen;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (we) begin
         wa_log.push_back(wa);
         wd_log.push_back(wd);
      end
      if (busy) busy_seen = 1'b1;
   end

   task automatic clear_logs();
      wa_log.delete();
      wd_log.delete();
      busy_seen = 1'b0;
   endtask

   task automatic do_start(input logic [CNT_W-1:0] n);
      start     = 1'b1;
      num_words = n;
      @(negedge clk);
      start     = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) begin
         total++; bad++;
         $display("FAIL send_byte_timeout byte_ready=%b required 1", byte_ready);
      end else begin
         @(negedge clk);
      end
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   // Returns cycles from the start cycle to the first cycle with done high (start cycle = 1).
   task automatic wait_done(output int cycles);
      int n = 0;
      while (!done && n < 1000) begin
         @(negedge clk);
         n++;
      end
      cycles = done ? (cyc - start_cyc + 1) : -1;
   endtask

   task automatic test_reset();
      total++;
      if ({byte_ready, we, busy, cpu_hold, done, err} !== 6'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b required=000000", {byte_ready, we, busy, cpu_hold, done, err});
      end
      total++;
      if (wa !== 32'h0 || wd !== 32'h0) begin
         bad++;
         $display("FAIL reset_bus wa=%h wd=%h required 0/0", wa, wd);
      end
   endtask

   task automatic test_single_word();
      int c;
      clear_logs();
      do_start(7'd1);
      total++;
      if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
         bad++;
         $display("FAIL single_busy busy=%b cpu_hold=%b required 1/1", busy, cpu_hold);
      end
      send_byte(8'h37); send_byte(8'hA4); send_byte(8'h03); send_byte(8'h00);
      wait_done(c);
      total++;
      if (c !== 6) begin bad++; $display("FAIL single_latency got=%0d required=6", c); end
      total++;
      if (wa_log.size() !== 1) begin
         bad++; $display("FAIL single_count got=%0d required=1", wa_log.size());
      end else if (wa_log[0] !== 32'h0 || wd_log[0] !== 32'h0003A437) begin
         bad++; $display("FAIL single_write wa=%h wd=%h required 00000000/0003a437", wa_log[0], wd_log[0]);
      end
      total++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         bad++; $display("FAIL single_end busy=%b err=%b required 0/0", busy, err);
      end
   endtask

   task automatic test_stalls();
      logic [31:0] exp_w[3];
      int c;
      exp_w[0] = 32'h7D040413; exp_w[1] = 32'h00802023; exp_w[2] = 32'h00400093;
      clear_logs();
      do_start(7'd3);
      send_byte(8'h13); send_byte(8'h04);
      @(negedge clk); @(negedge clk);
      send_byte(8'h04); send_byte(8'h7D);
      send_word(exp_w[1]);
      send_word(exp_w[2]);
      wait_done(c);
      total++;
      if (c !== 18) begin bad++; $display("FAIL stall_latency got=%0d required=18", c); end
      total++;
      if (wa_log.size() !== 3) begin
         bad++; $display("FAIL stall_count got=%0d required=3", wa_log.size());
      end else begin
         int e = 0;
         for (int i = 0; i < 3; i++)
            if (wa_log[i] !== 32'(4*i) || wd_log[i] !== exp_w[i]) begin
               e++;
               $display("FAIL stall_word%0d wa=%h wd=%h required %h/%h", i, wa_log[i], wd_log[i], 32'(4*i), exp_w[i]);
            end
         if (e != 0) bad++;
      end
   endtask

   task automatic test_range();
      clear_logs();
      do_start(7'd0);
      total++;
      if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL zero_words done=%b err=%b busy=%b required 1/0/0", done, err, busy);
      end
      repeat (3) @(negedge clk);
      total++;
      if (wa_log.size() !== 0) begin bad++; $display("FAIL zero_writes got=%0d required=0", wa_log.size()); end
      clear_logs();
      do_start(7'd65);
      total++;
      if (done !== 1'b1 || err !== 1'b1) begin
         bad++; $display("FAIL over_depth done=%b err=%b required 1/1", done, err);
      end
      repeat (3) @(negedge clk);
      total++;
      if (wa_log.size() !== 0 || busy_seen) begin
         bad++; $display("FAIL over_depth_quiet writes=%0d busy_seen=%b required 0/0", wa_log.size(), busy_seen);
      end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      do_start(7'd2);
      total++;
      if (err !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL start_clears err=%b done=%b required 0/0", err, done);
      end
      send_word(32'hDEADBEEF);
      send_byte(8'h55); send_byte(8'h66);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b required=1", busy); end
      reset = 1'b1;
      #1;
      total++;
      if ({byte_ready, we, busy, cpu_hold, done, err} !== 6'b0 || wa !== 32'h0 || wd !== 32'h0) begin
         bad++;
         $display("FAIL async_reset flags=%b wa=%h wd=%h required 000000/0/0",
                  {byte_ready, we, busy, cpu_hold, done, err}, wa, wd);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (wa_log.size() !== 1) begin
         bad++; $display("FAIL reset_writes got=%0d required=1", wa_log.size());
      end else if (wa_log[0] !== 32'h0 || wd_log[0] !== 32'hDEADBEEF) begin
         bad++; $display("FAIL reset_write wa=%h wd=%h required 00000000/deadbeef", wa_log[0], wd_log[0]);
      end
   endtask

   task automatic test_busy_start_extra();
      int c;
      bit rdy_seen = 1'b0;
      clear_logs();
      do_start(7'd1);
      send_byte(8'h11); send_byte(8'h22);
      start = 1'b1; num_words = 7'd3;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || byte_ready !== 1'b1) begin
         bad++; $display("FAIL busy_start busy=%b byte_ready=%b required 1/1", busy, byte_ready);
      end
      send_byte(8'h33); send_byte(8'h44);
      wait_done(c);
      total++;
      if (wa_log.size() !== 1 || wd_log[0] !== 32'h44332211) begin
         bad++; $display("FAIL busy_start_write count=%0d wd=%h required 1/44332211",
                         wa_log.size(), (wd_log.size() > 0) ? wd_log[0] : 32'hx);
      end
      byte_valid = 1'b1; byte_data = 8'hAA;
      repeat (4) begin
         if (byte_ready) rdy_seen = 1'b1;
         @(negedge clk);
      end
      byte_valid = 1'b0;
      total++;
      if (rdy_seen || wa_log.size() !== 1 || done !== 1'b1) begin
         bad++; $display("FAIL extra_bytes ready_seen=%b writes=%0d done=%b required 0/1/1",
                         rdy_seen, wa_log.size(), done);
      end
   endtask

   task automatic test_full_depth();
      int c;
      int e = 0;
      clear_logs();
      do_start(7'd64);
      for (int i = 0; i < DEPTH; i++) send_word(32'(i));
      wait_done(c);
      total++;
      if (c !== 321) begin bad++; $display("FAIL full_latency got=%0d required=321", c); end
      total++;
      if (wa_log.size() !== 64) begin
         bad++; $display("FAIL full_count got=%0d required=64", wa_log.size());
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (wa_log[i] !== 32'(4*i) || wd_log[i] !== 32'(i)) e++;
         if (e != 0 || wa_log[63] !== 32'hFC) begin
            bad++; $display("FAIL full_words errors=%0d last_wa=%h required 0/000000fc", e, wa_log[63]);
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
      @(negedge clk); @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_single_word();
      test_stalls();
      test_range();
      test_reset_mid();
      test_busy_start_extra();
      test_full_depth();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes instruction memory. Accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and drives a word-aligned write port into the instruction memory. Holds the core in reset (`cpu_hold`) while loading, so the fetch side only sees a complete program. Sits between the host/UART byte source and the imem write port.

## Interface
- `DEPTH`, 64: instruction memory size in words. Legal word indices are 0..DEPTH-1.
- `CNT_W`, 7: width of `num_words`. Must satisfy 2^CNT_W > DEPTH.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load session. Sampled only in IDLE or DONE.
- `num_words`  in  CNT_W  number of words to load. Sampled on an accepted `start`.
- `byte_valid`  in  1  byte source has data.
- `byte_data`  in  8  data byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  imem write enable, one cycle per word.
- `wa`  out  32  imem byte address, word-aligned: `{word_idx, 2'b00}` zero-extended.
- `wd`  out  32  packed write data.
- `busy`  out  1  session in progress.
- `cpu_hold`  out  1  equals `busy`; holds the core in reset.
- `done`  out  1  sticky; last session finished. Cleared by the next accepted `start`.
- `err`  out  1  sticky; last `start` requested `num_words > DEPTH`. Cleared by the next accepted `start`.

## Operation
- The FSM has four states: IDLE, RECV, WRITE, DONE.
- **IDLE / DONE, on `start`:**
  - Clear `done`, `err`, `byte_idx`, `word_idx` and the pack buffer.
  - If `num_words == 0`: go to DONE with `done = 1`.
  - If `num_words > DEPTH`: go to DONE with `err = 1` and `done = 1`. No writes occur.
  - Otherwise latch `count = num_words` and go to RECV.
- **RECV:**
  - `byte_ready = 1`.
  - A byte is accepted when `byte_valid && byte_ready`. It goes into buffer lane `byte_idx` (lane 0 = bits [7:0]), then `byte_idx` increments mod 4.
  - Accepting lane 3 moves the FSM to WRITE.
  - With `byte_valid = 0` the FSM waits indefinitely. No timeout.
- **WRITE:**
  - `we = 1`, `wa = word_idx << 2`, `wd` = the full buffer, `byte_ready = 0`.
  - If `word_idx == count - 1`: go to DONE and set `done = 1`.
  - Otherwise increment `word_idx` and return to RECV.
- **DONE:**
  - `busy = 0`, `byte_ready = 0`, `we = 0`.
  - Stays in DONE until the next `start`.
- **Busy rule:** `busy = 1` in RECV and WRITE only.
- **Start while busy:** `start` is ignored in RECV and WRITE.
- **Extra bytes:** bytes after the last word are never accepted (`byte_ready = 0`).
- **Address width:** `word_idx` never reaches DEPTH, so no wrap-around is possible.
- **Reset, including mid-session:** all state clears immediately. Any partial word is discarded and not written; words already written stay in imem.

## Timing
- **Reset values:** state = IDLE, `byte_ready = 0`, `we = 0`, `wa = 0`, `wd = 0`, `busy = 0`, `cpu_hold = 0`, `done = 0`, `err = 0`.
- **Registered outputs:** all outputs are decoded from registers only. There is no combinational path from `byte_valid`, `byte_data` or `start` to any output.
- **Session start:** an accepted `start` at edge N puts the FSM in RECV in cycle N+1, with `busy = 1` from cycle N+1.
- **Per-word cost:** 4 accepting RECV cycles plus 1 WRITE cycle = 5 cycles minimum per word.
- **Write timing:** `we` is high in the cycle after the edge that accepted lane 3.
- **Completion:** `done` rises in the cycle after the final WRITE cycle, and `busy` falls in that same cycle.
- **Full-program minimum:** a DEPTH-word program takes 5·DEPTH + 1 cycles from `start` to `done`.

## Structure
- **Package `imem_loader_pkg`:**
  - State enum `loader_state_t` (IDLE, RECV, WRITE, DONE).
  - Constants `WORD_BYTES = 4` and `LANE_W = 2`.
- **Sub-module `byte_packer`:**
  - Little-endian 4-lane shift/lane register.
  - Ports: `clk`, `reset`, `clr`, `push`, `byte_in[7:0]`; outputs `word_out[31:0]` and `last_lane`.
  - The top level owns the FSM, the counters and the handshake.

## Test plan
1. **Single word:** `start`, `num_words = 1`, bytes 37 A4 03 00 back-to-back.
   - Exactly one `we` pulse with `wa = 0x0` and `wd = 0x0003A437`.
   - `done = 1` six cycles after the `start` edge.
2. **Three words with source stalls:** deassert `byte_valid` for 2 cycles mid-word; words 0x7D040413, 0x00802023, 0x00400093.
   - Writes at `wa` = 0x0, 0x4, 0x8 with those values.
   - No byte lost or duplicated.
3. **Out-of-range counts:**
   - `num_words = 0`: `done = 1`, no `we`.
   - `num_words = 65` (DEPTH = 64): `err = 1`, `done = 1`, no `we`, `busy` never asserted.
4. **Reset mid-session:** after 6 of 8 bytes, pulse `reset`.
   - Only the write to `wa = 0` occurred.
   - All outputs return to reset values asynchronously, before the next clock edge.
5. **Start while busy / extra bytes:** pulse `start` during RECV, then supply 2 extra bytes after the last word.
   - The pulse is ignored.
   - `byte_ready = 0` after the final word; the extra bytes are never accepted.
6. **Full depth:** load 64 words with `wd = index`.
   - 64 writes, last at `wa = 0xFC`.
   - `done` at cycle 321.
